// File: rtl/mips_alu_unit_if.sv
// mips_alu_unit_if
// Purpose: groups the execute-stage ALU operand/opcode bus and its
// registered result/flag outputs so the ALU and its driver share one
// bundle.
// Signals:
//   opcode     [5:0]        instruction bits [31:26]
//   func_field [5:0]        instruction bits [5:0], R-type only
//   A          [WIDTH-1:0]  operand A (rs value)
//   B          [WIDTH-1:0]  operand B (rt value or extended immediate)
//   result     [WIDTH-1:0]  registered ALU result
//   zero                    registered flag, 1 when result is all zeros
// Modports:
//   master  drives opcode/func_field/A/B, observes result/zero
//   slave   the ALU side
interface mips_alu_unit_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       opcode;
  logic [5:0]       func_field;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output opcode, func_field, A, B,
    input  result, zero
  );

  modport slave (
    input  opcode, func_field, A, B,
    output result, zero
  );
endinterface

// File: rtl/mips_alu_unit.sv
// mips_alu_unit
// Purpose: registered MIPS execute-stage ALU. Decodes opcode (and
// func_field for R-type) into an internal operation, applies it to A
// and B, and registers the result together with a zero flag. Latency
// is one cycle and a new operation is accepted every cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; forces result=0, zero=1
//   bus    mips_alu_unit_if slave modport (opcode, func_field, A, B in;
//          result, zero out)
module mips_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_alu_unit_if.slave         bus
);

  // Internal ALU operation encoding produced by the decoder.
  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_LUI  = 4'd12;

  logic [3:0]       aluOp;
  logic [4:0]       shiftAmt;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  // Controller: opcode selects the operation directly for I-type;
  // opcode 0x00 defers to func_field. Anything unrecognised becomes
  // OP_NONE, which yields a zero result.
  always_comb begin
    aluOp = OP_NONE;
    case (bus.opcode)
      6'h00: begin
        case (bus.func_field)
          6'h20, 6'h21: aluOp = OP_ADD;
          6'h22, 6'h23: aluOp = OP_SUB;
          6'h24:        aluOp = OP_AND;
          6'h25:        aluOp = OP_OR;
          6'h26:        aluOp = OP_XOR;
          6'h27:        aluOp = OP_NOR;
          6'h2A:        aluOp = OP_SLT;
          6'h2B:        aluOp = OP_SLTU;
          6'h04:        aluOp = OP_SLL;
          6'h06:        aluOp = OP_SRL;
          6'h07:        aluOp = OP_SRA;
          default:      aluOp = OP_NONE;
        endcase
      end
      6'h23, 6'h2B, 6'h08, 6'h09: aluOp = OP_ADD;
      6'h04, 6'h05:               aluOp = OP_SUB;
      6'h0A:                      aluOp = OP_SLT;
      6'h0B:                      aluOp = OP_SLTU;
      6'h0C:                      aluOp = OP_AND;
      6'h0D:                      aluOp = OP_OR;
      6'h0E:                      aluOp = OP_XOR;
      6'h0F:                      aluOp = OP_LUI;
      default:                    aluOp = OP_NONE;
    endcase
  end

  // Variable shifts only honour the low five bits of A.
  assign shiftAmt = bus.A[4:0];

  // Datapath: add/sub wrap modulo 2^WIDTH, so signed and unsigned
  // variants share one adder and no overflow is reported.
  always_comb begin
    result_d = '0;
    case (aluOp)
      OP_ADD:  result_d = bus.A + bus.B;
      OP_SUB:  result_d = bus.A - bus.B;
      OP_AND:  result_d = bus.A & bus.B;
      OP_OR:   result_d = bus.A | bus.B;
      OP_XOR:  result_d = bus.A ^ bus.B;
      OP_NOR:  result_d = ~(bus.A | bus.B);
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_SLL:  result_d = bus.B << shiftAmt;
      OP_SRL:  result_d = bus.B >> shiftAmt;
      OP_SRA:  result_d = $signed(bus.B) >>> shiftAmt;
      OP_LUI:  result_d = {bus.B[15:0], 16'h0000};
      default: result_d = '0;
    endcase
  end

  // Output register, loaded every cycle. The zero flag is derived from
  // the value being loaded so it always agrees with result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= (result_d == '0);
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_mips_alu_unit.sv
// tb_mips_alu_unit
// Purpose: self-checking bench for mips_alu_unit. Directed scenarios
// from the ALU's documented behaviour plus randomized operations
// checked against a behavioural reference model.
module tb_mips_alu_unit;

  logic clk;
  logic rst_n;
  int   passCount;
  int   checkCount;

  mips_alu_unit_if #(.WIDTH(32)) bus ();

  mips_alu_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: computes the MIPS instruction result from its
  // architectural meaning. Returns {zero, result}.
  function automatic logic [32:0] refAlu(input logic [5:0] op, input logic [5:0] fn,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int          ia;
    int          ib;
    int unsigned amt;
    ia  = int'(a);
    ib  = int'(b);
    amt = int'(a) & 31;
    r   = 32'h0;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: r = a + b;
        6'h22, 6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: r = (ia < ib) ? 32'd1 : 32'd0;
        6'h2B: r = (a < b) ? 32'd1 : 32'd0;
        6'h04: r = b << amt;
        6'h06: r = b >> amt;
        6'h07: begin
          r = b >> amt;
          if (b[31]) for (int k = 0; k < int'(amt); k++) r[31-k] = 1'b1;
        end
        default: r = 32'h0;
      endcase
    end else begin
      case (op)
        6'h23, 6'h2B, 6'h08, 6'h09: r = a + b;
        6'h04, 6'h05: r = a - b;
        6'h0A: r = (ia < ib) ? 32'd1 : 32'd0;
        6'h0B: r = (a < b) ? 32'd1 : 32'd0;
        6'h0C: r = a & b;
        6'h0D: r = a | b;
        6'h0E: r = a ^ b;
        6'h0F: r = {16'h0, b[15:0]} * 32'd65536;
        default: r = 32'h0;
      endcase
    end
    return {(r == 32'h0), r};
  endfunction

  // Presents one operation before a rising edge and waits until just
  // after that edge so outputs can be sampled.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.opcode     = op;
    bus.func_field = fn;
    bus.A          = a;
    bus.B          = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    applyStimulus(6'h00, 6'h20, 32'h1234, 32'h1);
    applyStimulus(6'h00, 6'h20, 32'h1234, 32'h1);
    checkCount++;
    if (bus.result !== 32'h0)
      $display("[TB] FAIL reset_result: got %h expected %h", bus.result, 32'h0);
    else passCount++;
    checkCount++;
    if (bus.zero !== 1'b1)
      $display("[TB] FAIL reset_zero: got %b expected %b", bus.zero, 1'b1);
    else passCount++;
    rst_n = 1'b1;
  endtask

  task automatic test_add_and_lw;
    logic [31:0] expR [3];
    logic        expZ [3];
    logic [5:0]  ops  [3];
    logic [5:0]  fns  [3];
    ops = '{6'h00, 6'h00, 6'h23};
    fns = '{6'h20, 6'h24, 6'h00};
    expR = '{32'h00003333, 32'h00000000, 32'h00003333};
    expZ = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ops[i], fns[i], 32'h2222, 32'h1111);
      checkCount++;
      if (bus.result !== expR[i])
        $display("[TB] FAIL add_and_lw_result[%0d]: got %h expected %h", i, bus.result, expR[i]);
      else passCount++;
      checkCount++;
      if (bus.zero !== expZ[i])
        $display("[TB] FAIL add_and_lw_zero[%0d]: got %b expected %b", i, bus.zero, expZ[i]);
      else passCount++;
    end
  endtask

  task automatic test_branch;
    applyStimulus(6'h04, 6'h00, 32'h5555, 32'h5555);
    checkCount++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1)
      $display("[TB] FAIL beq: got %h/%b expected %h/%b", bus.result, bus.zero, 32'h0, 1'b1);
    else passCount++;
    applyStimulus(6'h05, 6'h00, 32'h5555, 32'h5554);
    checkCount++;
    if (bus.result !== 32'h1 || bus.zero !== 1'b0)
      $display("[TB] FAIL bne: got %h/%b expected %h/%b", bus.result, bus.zero, 32'h1, 1'b0);
    else passCount++;
  endtask

  task automatic test_slt;
    applyStimulus(6'h00, 6'h2A, 32'h1111, 32'h2222);
    checkCount++;
    if (bus.result !== 32'h1)
      $display("[TB] FAIL slt_small: got %h expected %h", bus.result, 32'h1);
    else passCount++;
    applyStimulus(6'h00, 6'h2A, 32'h80000000, 32'h7FFFFFFF);
    checkCount++;
    if (bus.result !== 32'h1)
      $display("[TB] FAIL slt_boundary: got %h expected %h", bus.result, 32'h1);
    else passCount++;
    applyStimulus(6'h00, 6'h2B, 32'h80000000, 32'h7FFFFFFF);
    checkCount++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1)
      $display("[TB] FAIL sltu_boundary: got %h/%b expected %h/%b", bus.result, bus.zero, 32'h0, 1'b1);
    else passCount++;
  endtask

  task automatic test_wrap;
    applyStimulus(6'h00, 6'h21, 32'hFFFFFFFF, 32'h1);
    checkCount++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1)
      $display("[TB] FAIL addu_wrap: got %h/%b expected %h/%b", bus.result, bus.zero, 32'h0, 1'b1);
    else passCount++;
    applyStimulus(6'h00, 6'h22, 32'h0, 32'h1);
    checkCount++;
    if (bus.result !== 32'hFFFFFFFF)
      $display("[TB] FAIL sub_wrap: got %h expected %h", bus.result, 32'hFFFFFFFF);
    else passCount++;
  endtask

  task automatic test_shift_lui_default;
    applyStimulus(6'h00, 6'h07, 32'h4, 32'h80000000);
    checkCount++;
    if (bus.result !== 32'hF8000000)
      $display("[TB] FAIL srav: got %h expected %h", bus.result, 32'hF8000000);
    else passCount++;
    applyStimulus(6'h00, 6'h04, 32'hFFFFFFE0, 32'hA5A5A5A5);
    checkCount++;
    if (bus.result !== 32'hA5A5A5A5)
      $display("[TB] FAIL sllv_zero_amount: got %h expected %h", bus.result, 32'hA5A5A5A5);
    else passCount++;
    applyStimulus(6'h0F, 6'h3F, 32'hDEADBEEF, 32'h00001234);
    checkCount++;
    if (bus.result !== 32'h12340000)
      $display("[TB] FAIL lui: got %h expected %h", bus.result, 32'h12340000);
    else passCount++;
    applyStimulus(6'h3F, 6'h20, 32'h2222, 32'h1111);
    checkCount++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1)
      $display("[TB] FAIL undefined_opcode: got %h/%b expected %h/%b", bus.result, bus.zero, 32'h0, 1'b1);
    else passCount++;
    applyStimulus(6'h00, 6'h3F, 32'h2222, 32'h1111);
    checkCount++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1)
      $display("[TB] FAIL undefined_func: got %h/%b expected %h/%b", bus.result, bus.zero, 32'h0, 1'b1);
    else passCount++;
  endtask

  task automatic test_reset_midstream;
    applyStimulus(6'h00, 6'h20, 32'h2222, 32'h1111);
    checkCount++;
    if (bus.result !== 32'h3333)
      $display("[TB] FAIL midstream_add: got %h expected %h", bus.result, 32'h3333);
    else passCount++;
    rst_n = 1'b0;
    applyStimulus(6'h00, 6'h20, 32'h4444, 32'h1111);
    checkCount++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1)
      $display("[TB] FAIL midstream_reset: got %h/%b expected %h/%b", bus.result, bus.zero, 32'h0, 1'b1);
    else passCount++;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [5:0]  ops [3];
    logic [5:0]  fns [3];
    logic [31:0] as  [3];
    logic [31:0] bs  [3];
    logic [32:0] exp;
    logic [32:0] prev;
    ops = '{6'h00, 6'h0D, 6'h00};
    fns = '{6'h22, 6'h00, 6'h27};
    as  = '{32'h00000010, 32'h0000F000, 32'h0F0F0000};
    bs  = '{32'h00000003, 32'h000000FF, 32'h00F0F0F0};
    prev = {bus.zero, bus.result};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      // Output must still hold the previous operation before this edge.
      checkCount++;
      if ({bus.zero, bus.result} !== prev)
        $display("[TB] FAIL b2b_hold[%0d]: got %h expected %h", i, {bus.zero, bus.result}, prev);
      else passCount++;
      bus.opcode     = ops[i];
      bus.func_field = fns[i];
      bus.A          = as[i];
      bus.B          = bs[i];
      @(posedge clk);
      #1;
      exp = refAlu(ops[i], fns[i], as[i], bs[i]);
      checkCount++;
      if ({bus.zero, bus.result} !== exp)
        $display("[TB] FAIL b2b_result[%0d]: got %h expected %h", i, {bus.zero, bus.result}, exp);
      else passCount++;
      prev = exp;
    end
  endtask

  task automatic test_random;
    logic [5:0]  opList [17];
    logic [5:0]  fnList [12];
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] exp;
    opList = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h09, 6'h04,
               6'h05, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F};
    fnList = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B, 6'h04, 6'h06};
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : opList[$urandom_range(0, 16)];
      fn = ($urandom_range(0, 9) == 0) ? 6'h07 : fnList[$urandom_range(0, 11)];
      if ($urandom_range(0, 19) == 0) fn = 6'($urandom);
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      applyStimulus(op, fn, a, b);
      exp = refAlu(op, fn, a, b);
      checkCount++;
      if (bus.result !== exp[31:0] || bus.zero !== exp[32])
        $display("[TB] FAIL random[%0d] op=%h fn=%h a=%h b=%h: got %h/%b expected %h/%b",
                 i, op, fn, a, b, bus.result, bus.zero, exp[31:0], exp[32]);
      else passCount++;
    end
  endtask

  // Scenario sequence; ends with the single summary line.
  initial begin
    passCount      = 0;
    checkCount     = 0;
    rst_n          = 1'b0;
    bus.opcode     = 6'h00;
    bus.func_field = 6'h00;
    bus.A          = 32'h0;
    bus.B          = 32'h0;
    test_reset();
    test_add_and_lw();
    test_branch();
    test_slt();
    test_wrap();
    test_shift_lui_default();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
